// File: rtl/alu_ctrl_pkg.sv
// Shared types and constants for the ALU sharing controller.
//   state_t : controller FSM states (IDLE, EXEC, RESP)
//   ctl_t   : opcode/funct/shamt bundle registered on accept
//   OP_*/FUNCT_* : ALU encodings used by issue logic and tests
package alu_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic [5:0] opcode;
    logic [5:0] funct;
    logic [4:0] shamt;
  } ctl_t;

  localparam logic [5:0] OP_RTYPE  = 6'b000000;
  localparam logic [5:0] FUNCT_SLL = 6'b000000;
  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_AND = 6'b100100;

  // Latency counter width; covers ALU_LAT up to 15.
  localparam int CNT_W = 4;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant, purely combinational.
//   req[1:0]   : request vector (bit i = requester i valid)
//   last_grant : requester granted most recently (0 or 1)
//   gnt[1:0]   : one-hot (or zero) grant
// A lone requester always wins; on a tie the requester that was not
// granted last time wins.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (req[0] && (!req[1] || last_grant)) begin
      gnt[0] = 1'b1;
    end else if (req[1]) begin
      gnt[1] = 1'b1;
    end
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one combinational ALU between two requesters.
// Round-robin arbitration in IDLE; the winning operation is registered and
// drives the ALU for ALU_LAT cycles (EXEC), then alu_out is captured and held
// on a tagged response port until accepted (RESP).
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   req{0,1}_valid/ready     : requester handshake (ready only in IDLE)
//   req{0,1}_opcode/funct/shamt/a/b : operation fields
//   alu_opcode/funct/shamt/inp1/inp2 : registered ALU operands
//   alu_out                  : ALU result
//   rsp_valid/ready/id/data  : response handshake, issuing requester, result
//   rsp_zero                 : result-is-zero flag (only when ALU_ZERO_FLAG_EN)
// Build option: define ALU_ZERO_FLAG_EN to add the rsp_zero output.
module alu_share_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ALU_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [5:0]        req0_opcode,
  input  logic [5:0]        req0_funct,
  input  logic [4:0]        req0_shamt,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [5:0]        req1_opcode,
  input  logic [5:0]        req1_funct,
  input  logic [4:0]        req1_shamt,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic [5:0]        alu_opcode,
  output logic [5:0]        alu_funct,
  output logic [4:0]        alu_shamt,
  output logic [DATA_W-1:0] alu_inp1,
  output logic [DATA_W-1:0] alu_inp2,
  input  logic [DATA_W-1:0] alu_out,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_data
`ifdef ALU_ZERO_FLAG_EN
  ,
  output logic              rsp_zero
`endif
);

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(ALU_LAT - 1);

  state_t            state_reg;
  logic              last_grant_reg;
  logic [CNT_W-1:0]  cnt_reg;
  ctl_t              ctl_reg;
  logic [DATA_W-1:0] a_reg;
  logic [DATA_W-1:0] b_reg;
  logic              id_reg;
  logic              rsp_valid_reg;
  logic [DATA_W-1:0] rsp_data_reg;

  logic [1:0]        gnt;
  logic              accept;
  ctl_t              win_ctl;
  logic [DATA_W-1:0] win_a;
  logic [DATA_W-1:0] win_b;

  rr_arb2 u_arb (
    .req        ({req1_valid, req0_valid}),
    .last_grant (last_grant_reg),
    .gnt        (gnt)
  );

  // Grants only matter in IDLE; outside IDLE both readies stay low.
  assign req0_ready = (state_reg == IDLE) && gnt[0];
  assign req1_ready = (state_reg == IDLE) && gnt[1];
  assign accept     = req0_ready || req1_ready;

  // Winner select: gnt is one-hot, so gnt[1] alone picks the source.
  always_comb begin
    win_ctl = gnt[1] ? ctl_t'{req1_opcode, req1_funct, req1_shamt}
                     : ctl_t'{req0_opcode, req0_funct, req0_shamt};
    win_a   = gnt[1] ? req1_a : req0_a;
    win_b   = gnt[1] ? req1_b : req0_b;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      last_grant_reg <= 1'b1;
      cnt_reg        <= '0;
      ctl_reg        <= '0;
      a_reg          <= '0;
      b_reg          <= '0;
      id_reg         <= 1'b0;
      rsp_valid_reg  <= 1'b0;
      rsp_data_reg   <= '0;
`ifdef ALU_ZERO_FLAG_EN
      rsp_zero       <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            ctl_reg        <= win_ctl;
            a_reg          <= win_a;
            b_reg          <= win_b;
            id_reg         <= gnt[1];
            last_grant_reg <= gnt[1];
            cnt_reg        <= CNT_INIT;
            state_reg      <= EXEC;
          end
        end
        EXEC: begin
          if (cnt_reg == '0) begin
            rsp_data_reg  <= alu_out;
            rsp_valid_reg <= 1'b1;
`ifdef ALU_ZERO_FLAG_EN
            rsp_zero      <= (alu_out == '0);
`endif
            state_reg     <= RESP;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        RESP: begin
          // Returning to IDLE here means the next grant is one cycle later.
          if (rsp_ready) begin
            rsp_valid_reg <= 1'b0;
            state_reg     <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign alu_opcode = ctl_reg.opcode;
  assign alu_funct  = ctl_reg.funct;
  assign alu_shamt  = ctl_reg.shamt;
  assign alu_inp1   = a_reg;
  assign alu_inp2   = b_reg;
  assign rsp_valid  = rsp_valid_reg;
  assign rsp_id     = id_reg;
  assign rsp_data   = rsp_data_reg;

endmodule
